// File: rtl/stream_relay_fifo.sv
// Elastic relay between pipeline actors: SEND/ACK input, DEPTH-entry FIFO with optional 1-of-DECIM decimation, SEND/RDY output.
// Latency: 2 cycles ACK-to-SEND. In1_ACK drops while full, and pops stall while Out1_RDY is low.
module stream_relay_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int DECIM = 1,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [W-1:0]  In1_DATA,
  input  logic          In1_SEND,
  input  logic [15:0]   In1_COUNT,
  output logic          In1_ACK,
  output logic [W-1:0]  Out1_DATA,
  output logic          Out1_SEND,
  output logic [15:0]   Out1_COUNT,
  input  logic          Out1_RDY,
  input  logic          Out1_ACK,
  output logic [LW-1:0] LEVEL
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [CW-1:0] PH_LAST = CW'(DECIM - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          active_q;
  logic          send_q, send_d;
  logic [W-1:0]  data_q, data_d;
  logic          ack, keep, pop;

  // Producer count and consumer acknowledge carry no information for a one-token relay.
  logic unused_inputs;
  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

  always_comb begin
    ack  = active_q & In1_SEND & (level_q != FULL);
    keep = ack & (phase_q == '0);
    pop  = active_q & (level_q != '0) & Out1_RDY;

    wr_ptr_d = keep ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(keep) - LW'(pop);

    phase_d = phase_q;
    if (ack) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + CW'(1);
    end

    send_d = pop;
    data_d = pop ? mem_q[rd_ptr_q] : data_q;
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge CLK) begin
    if (keep) begin
      mem_q[wr_ptr_q] <= In1_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      active_q <= 1'b0;
      send_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      active_q <= 1'b1;
      send_q   <= send_d;
      data_q   <= data_d;
    end
  end

  assign In1_ACK    = ack;
  assign Out1_SEND  = send_q;
  assign Out1_DATA  = data_q;
  assign Out1_COUNT = 16'h0001;
  assign LEVEL      = level_q;

endmodule

// File: tb/tb_stream_relay_fifo.sv
// Drives one token stream into a pass-all relay and a 1-of-3 decimating relay; a scoreboard checks both.
module tb_stream_relay_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic [W-1:0]  in_dat   [2];
  logic          in_send  [2];
  logic          in_ack   [2];
  logic [W-1:0]  out_dat  [2];
  logic          out_send [2];
  logic [15:0]   out_cnt  [2];
  logic [LW-1:0] level    [2];
  logic          out_rdy = 1'b0;
  logic          out_ack = 1'b0;
  logic [15:0]   in_cnt  = 16'h0;
  logic          done    = 1'b0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stream_relay_fifo #(.W(W), .DEPTH(DEPTH), .DECIM(g == 0 ? 1 : 3)) u_dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .In1_DATA  (in_dat[g]),
      .In1_SEND  (in_send[g]),
      .In1_COUNT (in_cnt),
      .In1_ACK   (in_ack[g]),
      .Out1_DATA (out_dat[g]),
      .Out1_SEND (out_send[g]),
      .Out1_COUNT(out_cnt[g]),
      .Out1_RDY  (out_rdy),
      .Out1_ACK  (out_ack),
      .LEVEL     (level[g])
    );
  end

  function automatic int dec_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model and scoreboard ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          active_m [2];
  int          lvl_m    [2];
  bit          send_m   [2];
  logic [15:0] last_m   [2];
  int          acc_m    [2];
  logic [15:0] sbm      [2][256];
  int          sb_wr    [2];
  int          sb_rd    [2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t got=%0h expected=%0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    active_m[i] = 1'b0;
    lvl_m[i]    = 0;
    send_m[i]   = 1'b0;
    last_m[i]   = 16'h0;
    acc_m[i]    = 0;
    sb_wr[i]    = 0;
    sb_rd[i]    = 0;
  endtask

  initial begin : monitor
    bit ack_e, pop_e, kept;
    for (int i = 0; i < 2; i++) model_reset(i);
    forever begin
      @(negedge CLK or posedge RESET or posedge done);
      if (done) begin
        for (int i = 0; i < 2; i++) begin
          chk("drain_pending", i, sb_wr[i] - sb_rd[i], 0);
          chk("drain_level", i, 32'(level[i]), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      if (RESET) begin
        #1;
        for (int i = 0; i < 2; i++) begin
          chk("rst_send", i, 32'(out_send[i]), 0);
          chk("rst_level", i, 32'(level[i]), 0);
          chk("rst_data", i, 32'(out_dat[i]), 0);
          chk("rst_ack", i, 32'(in_ack[i]), 0);
          chk("rst_count", i, 32'(out_cnt[i]), 1);
          model_reset(i);
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          ack_e = active_m[i] && in_send[i] && (lvl_m[i] != DEPTH);
          chk("ack", i, 32'(in_ack[i]), 32'(ack_e));
          chk("level", i, 32'(level[i]), lvl_m[i]);
          chk("send", i, 32'(out_send[i]), 32'(send_m[i]));
          chk("count", i, 32'(out_cnt[i]), 1);
          if (out_send[i] === 1'b1) begin
            chk("sb_nonempty", i, 32'(sb_wr[i] > sb_rd[i]), 1);
            if (sb_wr[i] > sb_rd[i]) begin
              last_m[i] = sbm[i][sb_rd[i] % 256];
              sb_rd[i]++;
            end
          end
          chk("data", i, 32'(out_dat[i]), 32'(last_m[i]));
          // Outcome of the coming edge, from the observable rules only.
          pop_e = active_m[i] && (lvl_m[i] != 0) && out_rdy;
          kept  = 1'b0;
          if (ack_e) begin
            if (acc_m[i] % dec_of(i) == 0) begin
              sbm[i][sb_wr[i] % 256] = in_dat[i];
              sb_wr[i]++;
              kept = 1'b1;
            end
            acc_m[i]++;
          end
          lvl_m[i]    = lvl_m[i] + int'(kept) - int'(pop_e);
          send_m[i]   = pop_e;
          active_m[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] tok[$];
  int          idx [2];
  bit          send_en;
  int          send_mode, rdy_mode;

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      in_send[i] = send_en && (idx[i] < tok.size());
      in_dat[i]  = (idx[i] < tok.size()) ? tok[idx[i]] : 16'h0;
    end
  endtask

  task automatic set_modes(input int sm, input int rm);
    send_mode = sm;
    rdy_mode  = rm;
    send_en   = (sm == 2) ? 1'($urandom_range(0, 1)) : (sm != 0);
    out_rdy   = (rm == 2) ? 1'($urandom_range(0, 1)) : (rm != 0);
    drive();
  endtask

  task automatic cyc(input int n);
    bit acked [2];
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) acked[i] = in_ack[i];
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) if (acked[i]) idx[i]++;
      if (send_mode == 2) send_en = 1'($urandom_range(0, 1));
      if (rdy_mode == 2) out_rdy = 1'($urandom_range(0, 1));
      in_cnt  = 16'($urandom);
      out_ack = 1'($urandom_range(0, 1));
      drive();
    end
  endtask

  initial begin : stimulus
    idx = '{0, 0};
    set_modes(0, 0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc(2);

    // back-to-back trio with an open consumer
    tok.push_back(16'h0011);
    tok.push_back(16'h0022);
    tok.push_back(16'h0033);
    set_modes(1, 1);
    cyc(8);

    // consumer stalled while six tokens are offered, then released
    set_modes(1, 0);
    for (int k = 1; k <= 6; k++) tok.push_back(16'h0100 + 16'(k));
    cyc(8);
    set_modes(1, 1);
    cyc(12);

    // continuous run 0..8 (decimating relay keeps every third accepted token)
    for (int k = 0; k < 9; k++) tok.push_back(16'(k));
    cyc(16);

    // build occupancy, start draining, then reset mid-stream
    set_modes(1, 0);
    for (int k = 0; k < 6; k++) tok.push_back(16'h0A00 + 16'(k));
    cyc(3);
    set_modes(1, 1);
    cyc(1);
    RESET = 1'b1;
    set_modes(0, 1);
    cyc(1);
    RESET = 1'b0;
    tok.delete();
    idx = '{0, 0};
    tok.push_back(16'hBEEF);
    set_modes(1, 1);
    cyc(6);

    // randomized producer and consumer stalls
    for (int k = 0; k < 40; k++) tok.push_back(16'($urandom_range(0, 65535)));
    set_modes(2, 2);
    cyc(200);
    set_modes(1, 1);
    cyc(60);
    set_modes(0, 1);
    cyc(10);
    done = 1'b1;
  end

endmodule
